// File: rtl/riscv_types_pkg.sv
// Shared types for the core's pipeline: stage control vector and stage-register states.
package riscv_types;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] alu_op;
  } riscv_control_t;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_skid_entry.sv
// One stage-register entry: payload, control vector and valid, with load and clear.
module pipe_entry_reg
  import riscv_types::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              load,
  input  logic              clear,
  input  logic              zero_data,
  input  logic [DATA_W-1:0] next_data,
  input  riscv_control_t    next_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output riscv_control_t    ctrl
);

  // Clear wins over load so a flush discards a same-cycle write.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (zero_data) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= next_data;
      ctrl  <= next_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with valid/ready back-pressure, flush and
// an optional 2-entry skid buffer that keeps upstream ready registered.
module pipe_stage_skid
  import riscv_types::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter bit          SKID_EN         = 1'b1,
  parameter bit          FLUSH_CTRL_ONLY = 1'b0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush_in,
  input  logic              up_valid_in,
  output logic              up_ready_out,
  input  logic [DATA_W-1:0] up_data_in,
  input  riscv_control_t    up_ctrl_in,
  output logic              dn_valid_out,
  input  logic              dn_ready_in,
  output logic [DATA_W-1:0] dn_data_out,
  output riscv_control_t    dn_ctrl_out,
  output logic [1:0]        occ_out
);

  pipe_state_e state_q, state_d;

  logic              accept, emit;
  logic              head_valid, skid_valid;
  logic [DATA_W-1:0] head_data, skid_data, head_next_data;
  riscv_control_t    head_ctrl, skid_ctrl, head_next_ctrl;
  logic              head_load, head_clear, head_zero, head_from_skid;
  logic              skid_load, skid_clear, skid_zero;

  generate
    if (SKID_EN) begin : g_ready_reg
      assign up_ready_out = (state_q != PS_FULL) & ~rst_in;
    end else begin : g_ready_comb
      assign up_ready_out = (~head_valid | dn_ready_in) & ~rst_in;
    end
  endgenerate

  assign accept = up_valid_in & up_ready_out;
  assign emit   = head_valid & dn_ready_in;

  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_clear     = 1'b0;
    head_zero      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    skid_zero      = 1'b0;
    if (flush_in) begin
      state_d    = PS_EMPTY;
      head_clear = 1'b1;
      head_zero  = ~FLUSH_CTRL_ONLY;
      skid_clear = 1'b1;
      skid_zero  = ~FLUSH_CTRL_ONLY;
    end else begin
      unique case (state_q)
        PS_EMPTY: begin
          if (accept) begin
            head_load = 1'b1;
            state_d   = PS_ONE;
          end
        end
        PS_ONE: begin
          if (accept && emit) begin
            head_load = 1'b1;
          end else if (accept && SKID_EN) begin
            skid_load = 1'b1;
            state_d   = PS_FULL;
          end else if (emit) begin
            head_clear = 1'b1;
            state_d    = PS_EMPTY;
          end
        end
        PS_FULL: begin
          if (emit) begin
            head_load      = 1'b1;
            head_from_skid = skid_valid;
            skid_clear     = 1'b1;
            state_d        = PS_ONE;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= PS_EMPTY;
    else        state_q <= state_d;
  end

  assign head_next_data = head_from_skid ? skid_data : up_data_in;
  assign head_next_ctrl = head_from_skid ? skid_ctrl : up_ctrl_in;

  pipe_entry_reg #(.DATA_W(DATA_W)) u_head (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .load      (head_load),
    .clear     (head_clear),
    .zero_data (head_zero),
    .next_data (head_next_data),
    .next_ctrl (head_next_ctrl),
    .valid     (head_valid),
    .data      (head_data),
    .ctrl      (head_ctrl)
  );

  generate
    if (SKID_EN) begin : g_skid
      pipe_entry_reg #(.DATA_W(DATA_W)) u_skid (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .load      (skid_load),
        .clear     (skid_clear),
        .zero_data (skid_zero),
        .next_data (up_data_in),
        .next_ctrl (up_ctrl_in),
        .valid     (skid_valid),
        .data      (skid_data),
        .ctrl      (skid_ctrl)
      );
    end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = '0;
    end
  endgenerate

  assign dn_valid_out = head_valid;
  assign dn_data_out  = head_data;
  assign dn_ctrl_out  = head_valid ? head_ctrl : '0;
  assign occ_out      = {state_q == PS_FULL, state_q == PS_ONE};

endmodule
